// File: rtl/wb_ram_burst_if.sv
// Wishbone B4 slave-side bus bundle for wb_ram_burst; clock and reset travel separately.
interface wb_ram_burst_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wr_dat;
  logic [DW-1:0]   rd_dat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, wr_dat, sel, we, cyc, stb, cti, bte,
    input  rd_dat, ack, err, rty
  );

  modport slave (
    input  adr, wr_dat, sel, we, cyc, stb, cti, bte,
    output rd_dat, ack, err, rty
  );
endinterface

// File: rtl/wb_ram_burst.sv
// Wishbone B4 SRAM slave with registered-feedback bursts; first ack 1+WAIT_STATES cycles after the request,
// then one beat per clock while stb is held; stb low stalls the burst, cyc low abandons it.
module wb_ram_burst #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input logic          wb_clk_i,
  input logic          wb_rst_n_i,
  wb_ram_burst_if.slave bus
);
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int WAW = AW - LSB;
  localparam int CW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic [WAW-1:0] waddr;
  logic [WAW-1:0] waddr_nxt;
  logic           oor;
  logic [DW-1:0]  rd_dat;
  logic [DW-1:0]  mem [DEPTH];
  logic           req;
  logic           beat;
  logic           unused_adr;

  // Word counters are kept at full bus width so a linear burst can run past the top and raise err.
  function automatic logic [WAW-1:0] burst_next(input logic [WAW-1:0] w, input logic [1:0] bte);
    logic [WAW-1:0] inc;
    inc = w + WAW'(1);
    case (bte)
      2'b01:   burst_next = {w[WAW-1:2], inc[1:0]};
      2'b10:   burst_next = {w[WAW-1:3], inc[2:0]};
      2'b11:   burst_next = {w[WAW-1:4], inc[3:0]};
      default: burst_next = inc;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [WAW-1:0] w);
    out_of_range = |(w >> IW);
  endfunction

  assign req        = bus.cyc & bus.stb;
  assign beat       = (state == BEAT) & req;
  assign bus.ack    = beat & ~oor;
  assign bus.err    = beat & oor;
  assign bus.rty    = 1'b0;
  assign bus.rd_dat = rd_dat;
  assign unused_adr = ^bus.adr;

  always_comb begin
    waddr_nxt = waddr;
    if (state == IDLE && req)
      waddr_nxt = bus.adr[AW-1:LSB];
    else if (beat && bus.cti == 3'b010)
      waddr_nxt = burst_next(waddr, bus.bte);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      waddr    <= '0;
      oor      <= 1'b0;
    end else begin
      waddr <= waddr_nxt;
      oor   <= out_of_range(waddr_nxt);
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= CW'(WAIT_STATES);
            end else begin
              state <= BEAT;
            end
          end
        end
        WAIT: begin
          if (!bus.cyc)
            state <= IDLE;
          else if (wait_cnt == CW'(1))
            state <= BEAT;
          else
            wait_cnt <= wait_cnt - CW'(1);
        end
        BEAT: begin
          if (!bus.cyc)
            state <= IDLE;
          else if (bus.stb && bus.cti != 3'b010 && bus.cti != 3'b001)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch the word the counter will hold next cycle so read data lines up with each ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)
      rd_dat <= '0;
    else if (out_of_range(waddr_nxt))
      rd_dat <= '0;
    else
      rd_dat <= mem[waddr_nxt[IW-1:0]];
  end

  always_ff @(posedge wb_clk_i) begin
    if (bus.ack && bus.we) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.sel[i])
          mem[waddr[IW-1:0]][8*i +: 8] <= bus.wr_dat[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_ram_burst.sv
// Scoreboard bench for wb_ram_burst: one zero-wait and one two-wait instance behind a shared master.
module tb_wb_ram_burst;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          err;
    bit          chk;
    logic [31:0] dat;
    int          id;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          cnt = 0;
  logic [31:0] wd [16];
  logic [31:0] ed [16];

  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb, tgt;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        m_ack, m_err;
  logic [31:0] m_dat;

  wb_ram_burst_if #(.DW(32), .AW(32)) b0 ();
  wb_ram_burst_if #(.DW(32), .AW(32)) b2 ();

  wb_ram_burst #(.DW(32), .AW(32), .DEPTH(4096), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b0));
  wb_ram_burst #(.DW(32), .AW(32), .DEPTH(4096), .WAIT_STATES(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b2));

  assign b0.adr = adr;  assign b0.wr_dat = wdat; assign b0.sel = sel; assign b0.we = we;
  assign b0.cyc = cyc & ~tgt; assign b0.stb = stb; assign b0.cti = cti; assign b0.bte = bte;
  assign b2.adr = adr;  assign b2.wr_dat = wdat; assign b2.sel = sel; assign b2.we = we;
  assign b2.cyc = cyc & tgt;  assign b2.stb = stb; assign b2.cti = cti; assign b2.bte = bte;
  assign m_ack = tgt ? b2.ack : b0.ack;
  assign m_err = tgt ? b2.err : b0.err;
  assign m_dat = tgt ? b2.rd_dat : b0.rd_dat;

  always @(posedge clk) cnt <= cnt + 1;

  // Monitor: every ack/err must match the head of the expectation queue.
  initial forever begin
    @(negedge clk);
    if (m_ack || m_err) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat: unexpected ack=%0b err=%0b at cycle %0d, want no response", m_ack, m_err, cnt);
      end else begin
        e = q.pop_front();
        if (cnt != e.cyc || m_err != e.err || m_ack == m_err || (e.chk && m_dat !== e.dat)) begin
          fails++;
          $display("FAIL beat id%0d: got cyc=%0d ack=%0b err=%0b dat=%h, want cyc=%0d err=%0b dat=%h",
                   e.id, cnt, m_ack, m_err, m_dat, e.cyc, e.err, e.dat);
        end
      end
    end
  end

  task automatic check(input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL check id%0d: got %h want %h", id, act, exp);
    end
  endtask

  task automatic wait_beat(input int id);
    int t = 0;
    do begin @(negedge clk); t++; end while (!(m_ack || m_err) && t < 20);
    tests++;
    if (!(m_ack || m_err)) begin
      fails++;
      $display("FAIL timeout id%0d: no ack/err within %0d cycles, want a beat", id, t);
    end
  endtask

  // Issue an n-beat cycle; beats from err_from onward are expected to error.
  task automatic run(input int id, input int n, input logic [31:0] a, input bit w,
                     input logic [3:0] s, input logic [2:0] ct, input logic [1:0] bt, input int err_from);
    exp_t x;
    int   c0, ws;
    @(posedge clk); #1;
    c0 = cnt;
    ws = tgt ? 2 : 0;
    for (int k = 0; k < n; k++) begin
      x.cyc = c0 + 1 + ws + k;
      x.err = (k >= err_from);
      x.chk = !w || x.err;
      x.dat = x.err ? 32'd0 : ed[k];
      x.id  = id;
      q.push_back(x);
    end
    adr = a; we = w; sel = s; bte = bt; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < n; k++) begin
      cti  = (n == 1) ? ct : ((k == n - 1) ? 3'b111 : ct);
      wdat = wd[k];
      wait_beat(id);
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  initial begin
    adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b000; bte = 2'b00; tgt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(1, {29'd0, b0.ack, b0.err, b0.rty}, 32'd0);
    check(2, {29'd0, b2.ack, b2.err, b2.rty}, 32'd0);
    check(3, b0.rd_dat, 32'd0);
    check(4, b2.rd_dat, 32'd0);
    rst_n = 1'b1;

    // Classic write/read, full and partial byte lanes
    wd[0] = 32'hDEADBEEF; run(10, 1, 32'h10, 1, 4'hF, 3'b000, 2'b00, 99);
    ed[0] = 32'hDEADBEEF; run(11, 1, 32'h10, 0, 4'hF, 3'b000, 2'b00, 99);
    wd[0] = 32'h11223344; run(20, 1, 32'h20, 1, 4'hF, 3'b000, 2'b00, 99);
    wd[0] = 32'hAABBCCDD; run(21, 1, 32'h20, 1, 4'b0101, 3'b000, 2'b00, 99);
    ed[0] = 32'h11BB33DD; run(22, 1, 32'h20, 0, 4'hF, 3'b000, 2'b00, 99);
    wd[0] = 32'h11223344; run(23, 1, 32'h24, 1, 4'hF, 3'b000, 2'b00, 99);
    wd[0] = 32'hAABBCCDD; run(24, 1, 32'h24, 1, 4'b1010, 3'b000, 2'b00, 99);
    ed[0] = 32'hAA22CC44; run(25, 1, 32'h24, 0, 4'hF, 3'b000, 2'b00, 99);

    // Two wait states: 8-beat linear write then read of words 0x40..0x47
    tgt = 1'b1;
    for (int k = 0; k < 8; k++) begin wd[k] = 32'h1000_0040 + k; ed[k] = 32'h1000_0040 + k; end
    run(30, 8, 32'h100, 1, 4'hF, 3'b010, 2'b00, 99);
    run(31, 8, 32'h100, 0, 4'hF, 3'b010, 2'b00, 99);
    // Dropping cyc during the wait phase must not produce an ack
    @(posedge clk); #1;
    adr = 32'h100; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(posedge clk);
    ed[0] = 32'h1000_0041; run(32, 1, 32'h104, 0, 4'hF, 3'b000, 2'b00, 99);
    tgt = 1'b0;

    // Wrapping bursts: wrap4 from word 6, wrap8 from 0xE, wrap16 from 0x1F
    for (int k = 0; k < 4; k++) wd[k] = 32'hA000_0000 + k;
    run(40, 4, 32'h18, 1, 4'hF, 3'b010, 2'b01, 99);
    ed[0] = 32'hA0000002; ed[1] = 32'hA0000003; ed[2] = 32'hA0000000; ed[3] = 32'hA0000001;
    run(41, 4, 32'h10, 0, 4'hF, 3'b010, 2'b00, 99);
    ed[0] = 32'hA0000003; ed[1] = 32'hA0000000; ed[2] = 32'hA0000001; ed[3] = 32'hA0000002;
    run(42, 4, 32'h14, 0, 4'hF, 3'b010, 2'b01, 99);
    for (int k = 0; k < 3; k++) ed[k] = 32'hA0000000;
    run(43, 3, 32'h18, 0, 4'hF, 3'b001, 2'b00, 99);
    for (int k = 0; k < 4; k++) wd[k] = 32'hB000_0000 + k;
    run(44, 4, 32'h38, 1, 4'hF, 3'b010, 2'b10, 99);
    ed[0] = 32'hB0000001; ed[1] = 32'hB0000002; ed[2] = 32'hB0000003;
    run(45, 3, 32'h3C, 0, 4'hF, 3'b010, 2'b10, 99);
    wd[0] = 32'hC0000000; wd[1] = 32'hC0000001;
    run(46, 2, 32'h7C, 1, 4'hF, 3'b010, 2'b11, 99);
    ed[0] = 32'hC0000001; run(47, 1, 32'h40, 0, 4'hF, 3'b000, 2'b00, 99);

    // Out-of-range: err instead of ack, no write, per-beat check at the top
    wd[0] = 32'h12345678; run(50, 1, 32'h0, 1, 4'hF, 3'b000, 2'b00, 99);
    wd[0] = 32'hFFFFFFFF; run(51, 1, 32'h4000, 1, 4'hF, 3'b000, 2'b00, 0);
    ed[0] = 32'h12345678; run(52, 1, 32'h0, 0, 4'hF, 3'b000, 2'b00, 99);
    run(53, 1, 32'h4000, 0, 4'hF, 3'b000, 2'b00, 0);
    wd[0] = 32'h5555AAAA; wd[1] = 32'h6666BBBB;
    run(54, 2, 32'h3FF8, 1, 4'hF, 3'b010, 2'b00, 99);
    ed[0] = 32'h5555AAAA; ed[1] = 32'h6666BBBB;
    run(55, 3, 32'h3FF8, 0, 4'hF, 3'b010, 2'b00, 2);

    // Reset on the third beat of an 8-beat write burst
    wd[0] = 32'h77777777; run(60, 1, 32'h208, 1, 4'hF, 3'b000, 2'b00, 99);
    @(posedge clk); #1;
    e.cyc = cnt + 1; e.err = 1'b0; e.chk = 1'b0; e.dat = '0; e.id = 61; q.push_back(e);
    e.cyc = cnt + 2; q.push_back(e);
    adr = 32'h200; we = 1'b1; sel = 4'hF; bte = 2'b00; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
    wdat = 32'hC0C0_0000;
    wait_beat(61); @(posedge clk); #1;
    wdat = 32'hC0C0_0001;
    wait_beat(61); @(posedge clk); #1;
    wdat = 32'hC0C0_0002;
    check(62, {31'd0, m_ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check(63, {31'd0, m_ack}, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    rst_n = 1'b1;
    ed[0] = 32'h77777777; run(64, 1, 32'h208, 0, 4'hF, 3'b000, 2'b00, 99);
    ed[0] = 32'hC0C00001; run(65, 1, 32'h204, 0, 4'hF, 3'b000, 2'b00, 99);
    ed[0] = 32'hC0C00000; run(66, 1, 32'h200, 0, 4'hF, 3'b000, 2'b00, 99);

    repeat (4) @(posedge clk);
    check(70, q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
